// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: packs regfile/dmem writes into 48-bit records, queues them,
// and streams each record out MSB-first as six bytes over a valid/ready link.
module commit_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter bit FILTER_R0 = 1'b1,
    parameter int CNT_W     = 16,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rf_we,
    input  logic [4:0]       rf_reg,
    input  logic [31:0]      rf_data,
    input  logic             dm_we,
    input  logic [11:0]      dm_addr,
    input  logic [31:0]      dm_data,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [CW-1:0]    fifo_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state;
    logic [47:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pend_vld, pend_vld_nxt;
    logic [47:0]   pend_rec, pend_nxt;
    logic [47:0]   shreg;
    logic [2:0]    idx;

    logic          rf_ev, dm_ev, pop, full, push;
    logic [47:0]   rf_rec, dm_rec, push_rec;
    logic [1:0]    n_drop;
    logic [CNT_W:0] drop_sum;

    assign rf_ev  = rf_we && !(FILTER_R0 && rf_reg == 5'd0);
    assign dm_ev  = dm_we;
    assign rf_rec = {2'b01, 2'b00, 7'd0, rf_reg, rf_data};
    assign dm_rec = {2'b10, 2'b00, dm_addr, dm_data};

    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign pop  = (state == IDLE) && (fifo_count != '0);
    assign full = (fifo_count == FULL_CNT) && !pop;

    always_comb begin
        push         = 1'b0;
        push_rec     = rf_rec;
        pend_vld_nxt = pend_vld;
        pend_nxt     = pend_rec;
        n_drop       = 2'd0;
        if (!full) begin
            pend_vld_nxt = 1'b0;
            if (pend_vld) begin
                push     = 1'b1;
                push_rec = pend_rec;
                if (rf_ev) begin
                    pend_vld_nxt = 1'b1;
                    pend_nxt     = rf_rec;
                    n_drop       = {1'b0, dm_ev};
                end else if (dm_ev) begin
                    pend_vld_nxt = 1'b1;
                    pend_nxt     = dm_rec;
                end
            end else if (rf_ev) begin
                push     = 1'b1;
                push_rec = rf_rec;
                if (dm_ev) begin
                    pend_vld_nxt = 1'b1;
                    pend_nxt     = dm_rec;
                end
            end else if (dm_ev) begin
                push     = 1'b1;
                push_rec = dm_rec;
            end
        end else if (pend_vld) begin
            n_drop = {1'b0, rf_ev} + {1'b0, dm_ev};
        end else if (rf_ev) begin
            pend_vld_nxt = 1'b1;
            pend_nxt     = rf_rec;
            n_drop       = {1'b0, dm_ev};
        end else if (dm_ev) begin
            pend_vld_nxt = 1'b1;
            pend_nxt     = dm_rec;
        end
    end

    assign drop_sum = {1'b0, drop_count} + {{(CNT_W-1){1'b0}}, n_drop};

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_rec;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            pend_vld   <= 1'b0;
            pend_rec   <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            pend_vld   <= pend_vld_nxt;
            pend_rec   <= pend_nxt;
            if (n_drop != 2'd0) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            end
        end
    end

    // Shifting on every accepted byte leaves shreg zero once a record is fully sent.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    shreg    <= mem[rd_ptr];
                    idx      <= '0;
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: if (tx_ready) begin
                    shreg <= {shreg[39:0], 8'h00};
                    if (idx == 3'd5) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx_data = shreg[47:40];

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Observation stage downstream of the processor top level. Captures architectural side effects from the top-level debug outputs: regfile writes (ctrl_writeReg / data_writeReg with the regfile write enable) and dmem writes (address / data / wren).
- Packs each side effect into a 48-bit trace record and buffers records in a FIFO.
- Streams records out as bytes over a valid/ready link toward a UART or JTAG bridge, for hardware bring-up and grading comparison.
- Runs on the processor_clock domain.

Parameters:
- DEPTH, 16: FIFO depth in records. Power of two, 4..256.
- FILTER_R0, 1: when 1, regfile writes to r0 are ignored. They are not recorded and not counted as drops.
- CNT_W, 16: drop_count width.

Ports:
- clock  input  1  processor clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- rf_we  input  1  regfile write enable.
- rf_reg  input  5  regfile destination register.
- rf_data  input  32  regfile write data.
- dm_we  input  1  dmem write enable.
- dm_addr  input  12  dmem word address.
- dm_data  input  32  dmem write data.
- tx_data  output  8  trace byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  sink accepts the byte.
- fifo_count  output  clog2(DEPTH+1)  occupied FIFO entries. Excludes the pending slot and the serializer.
- drop_count  output  CNT_W  number of dropped records, saturating.
- overflow  output  1  sticky; set on the first drop.

Behaviour:
- Reset (async assert, sync-released by the user): FIFO empty, pending slot empty, serializer IDLE. Outputs: tx_valid=0, tx_data=0, fifo_count=0, drop_count=0, overflow=0.
- Record format, 48 bits:
  - [47:46] kind: 01 = regfile, 10 = dmem.
  - [45:44] = 00.
  - [43:32] tag: rf_reg zero-extended, or dm_addr.
  - [31:0] data.
- Candidates each cycle, in priority order: pending slot, then rf event (rf_we, passing the filter), then dm event (dm_we).
- The FIFO accepts at most one push per cycle.
- FIFO not full:
  - The highest-priority candidate is pushed.
  - The next candidate goes to the pending slot. The slot is free, since a pending entry was either just pushed or absent.
  - A third candidate is dropped.
- FIFO full:
  - An existing pending entry is held.
  - If the slot is empty, the first new candidate fills it.
  - All other new candidates are dropped.
- Simultaneous pop and push on a full FIFO: the pop frees space in the same cycle, so the push succeeds. fifo_count stays unchanged.
- Drop handling:
  - Each dropped record increments drop_count by 1, saturating at all-ones.
  - Two drops in one cycle add 2, still saturating.
  - overflow=1 from the edge of the first drop until reset.
- Serializer FSM:
  - IDLE: if the FIFO is non-empty, pop the head into a 48-bit shift register, set idx=0, go to SEND.
  - SEND: tx_valid=1, tx_data = byte idx, most significant byte first (idx 0 = bits [47:40]).
  - On tx_valid & tx_ready: if idx<5, idx+1. At idx=5, go to IDLE.
  - SEND→IDLE→SEND: a one-cycle bubble between records is permitted and required (simplicity over throughput).
- Handshake rules:
  - tx_data is stable while tx_valid=1 && tx_ready=0.
  - tx_valid never drops without a transfer.
  - tx_ready is ignored in IDLE.
- Latency: an event sampled at edge N with an empty FIFO and IDLE serializer is popped at edge N+1. tx_valid=1 with byte 0 after edge N+1, so the minimum is 2 edges.
- fifo_count is registered and reflects pushes and pops at the same edge.
- Pointers wrap modulo DEPTH. Full/empty are derived from the count, not from pointer equality.
- Reset mid-transfer: everything clears immediately. A partially sent record is lost and no further bytes are sent.

Test Plan:
- Single regfile write: rf_we=1, rf_reg=5, rf_data=0xDEADBEEF, tx_ready=1 → bytes 40,05,DE,AD,BE,EF. tx_valid first high 2 edges after the event; drop_count=0.
- Single dmem write: dm_we=1, dm_addr=0xABC, dm_data=0x00000001 → bytes 8A,BC,00,00,00,01.
- Simultaneous writes: rf(3, 0x11) and dm(0x010, 0x22) in the same cycle → the rf record is followed by the dm record. fifo_count peaks at 1 then 1 again, with the pending slot used; no drops.
- Back-pressure: tx_ready=0 for 10 cycles during byte 2 → tx_data holds the byte 2 value throughout; the remaining bytes follow in order when tx_ready=1.
- Overflow, DEPTH=4, tx_ready=0: 8 consecutive rf writes → fifo_count=4, pending slot held. Serializer holds 1 record, so drop_count=2 and overflow=1. After tx_ready=1 the first 6 records emerge in order.
- r0 filter plus reset: an rf write to r0 produces no bytes. Then assert reset low mid-record → tx_valid=0 and fifo_count=0 immediately, drop_count=0, overflow=0.
